pfd_loop_filter: RTL and testbench
==================================

Name: pfd_loop_filter

Overview:
- Digital PI loop filter between stdPFD and the DCO.
- Consumes the PFD `fast`/`slow` pulses, measures each phase-error pulse width in `clk` cycles, and integrates it.
- Produces the `maxVal`/`duty` control words for stdDCO8/stdDCOW, closing the resonate-and-fire frequency-locking loop.

Parameters:
- W, 8, control word width (matches the DCO W).
- EW, 8, signed error-counter width.
- KP_SHIFT, 1, proportional gain = 2^-KP_SHIFT.
- KI_SHIFT, 3, integrator fractional bits (integral gain = 2^-KI_SHIFT).
- INIT_VAL, 128, maxVal after reset.
- MIN_VAL, 2, lower clamp of maxVal.
- MAX_VAL, 255, upper clamp of maxVal (≤ 2^W-1).
- LOCK_TOL, 1, |err| at or below this counts as in-lock.
- LOCK_CNT, 4, consecutive in-lock updates needed to assert `locked`.

Ports:
- clk  in  1  system clock; all flops on posedge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted); deassertion is synchronous to clk by the integrator.
- fast  in  1  PFD fast output (asynchronous level).
- slow  in  1  PFD slow output (asynchronous level).
- hold  in  1  freeze: pulses are still measured, but integ/maxVal are not updated.
- maxVal  out  W  DCO cycle control word.
- duty  out  W  DCO duty word, always maxVal>>1.
- upd  out  1  one-cycle strobe when maxVal/duty change.
- locked  out  1  lock indicator (LOCK_DETECT_EN only; otherwise tied 0).

Behaviour:
- Reset values (reset low): maxVal=INIT_VAL, duty=INIT_VAL>>1, upd=0, locked=0, integ=INIT_VAL<<KI_SHIFT, err=0, state=IDLE, synchronisers=0.
- Synchronisation: fast and slow each pass through 2 flops, giving f_s and s_s. Latency is 2 clk.
- Integrator width: signed integ, W+KI_SHIFT+2 bits.
- States:
  - IDLE: if f_s^s_s, go to MEASURE and load err = +1 if s_s, -1 if f_s.
  - MEASURE: each cycle with s_s&~f_s, err++; with f_s&~s_s, err--. err saturates at ±(2^(EW-1)-1) and does not wrap. f_s&s_s (PFD reset overlap) leaves err unchanged and stays in MEASURE. When f_s=s_s=0, go to UPDATE.
  - UPDATE (1 cycle):
    - If hold=0: integ += err, then clamp integ to [MIN_VAL<<KI_SHIFT, MAX_VAL<<KI_SHIFT]. Then maxVal <= clamp((integ_new>>>KI_SHIFT) + (err>>>KP_SHIFT), MIN_VAL, MAX_VAL); duty <= that value >>1; upd=1 in the following cycle.
    - If hold=1: nothing changes and upd stays 0.
    - Go to IDLE and clear err.
- Sign convention: slow (signal edge first, DCO early) → positive err → longer period. fast → negative err.
- Latency: upd asserts 4 clk after the last high sample of the raw pulse (2 sync + detect + UPDATE).
- A pulse shorter than one clk may be missed; this is accepted.
- Reset mid-MEASURE: all state returns to its reset value immediately, and the partial pulse is discarded.
- If a new pulse starts while in UPDATE, it is caught in IDLE on the next cycle; no pulse is lost because the synchroniser level persists.

Optional Feature:
- LOCK_DETECT_EN:
  - Defined: a saturating counter lockCnt (clog2(LOCK_CNT+1) bits) increments on each UPDATE with |err| ≤ LOCK_TOL and clears on an UPDATE with |err| > LOCK_TOL.
  - locked=1 while lockCnt==LOCK_CNT, registered, and updates in the same cycle as upd.
  - hold=1 UPDATEs do not change lockCnt.
  - Undefined: no counter is built and locked is a constant 0.

Decomposition:
- Shared header rfn_defs.vh holds:
  - state encodings PLF_IDLE=2'd0, PLF_MEASURE=2'd1, PLF_UPDATE=2'd2;
  - the default gain constants.
- One sub-module, pfd_sync2: a 2-flop synchroniser with async active-low clear, instantiated for fast and slow.

Test Plan (defaults):
- Slow pulse 8 clk wide → err=+8, integ=1032, maxVal=129+4=133, duty=66, upd high 1 cycle.
- After reset, fast pulse 8 clk wide → err=-8, integ=1016, maxVal=127-4=123, duty=61.
- 20 fast pulses of 100 clk each → maxVal clamps at 2, integ clamps at 16, and there is no wrap to large values.
- Slow pulse 200 clk → err saturates at +127 and maxVal=MAX_VAL clamp (143+63=206 ≤ 255, so maxVal=206).
- hold=1 with a slow pulse of 8 → maxVal stays 128 and upd=0. Then reset pulsed low mid-pulse → all outputs return to reset values.
- LOCK_DETECT_EN: 4 slow pulses of 1 clk → locked=1 with the 4th upd. Next pulse of 5 clk → locked=0 on its upd.

Source files
------------

// File: rtl/pfd_loop_filter_pkg.sv
// rtl/pfd_loop_filter_pkg.sv - shared state encodings and default gains for pfd_loop_filter
// Contents: plf_state_e (IDLE/MEASURE/UPDATE) and PLF_*_DEF default parameter values.
package pfd_loop_filter_pkg;

  typedef enum logic [1:0] {
    PLF_IDLE    = 2'd0,
    PLF_MEASURE = 2'd1,
    PLF_UPDATE  = 2'd2
  } plf_state_e;

  localparam int PLF_W_DEF        = 8;
  localparam int PLF_EW_DEF       = 8;
  localparam int PLF_KP_SHIFT_DEF = 1;
  localparam int PLF_KI_SHIFT_DEF = 3;
  localparam int PLF_INIT_VAL_DEF = 128;
  localparam int PLF_MIN_VAL_DEF  = 2;
  localparam int PLF_MAX_VAL_DEF  = 255;
  localparam int PLF_LOCK_TOL_DEF = 1;
  localparam int PLF_LOCK_CNT_DEF = 4;

endpackage

// File: rtl/pfd_loop_filter_sync2.sv
// rtl/pfd_loop_filter_sync2.sv - two-flop synchroniser (module pfd_sync2) with async active-low clear
// Ports: clk - sampling clock; reset - async clear, active low; d - asynchronous level; q - synchronised level.
module pfd_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pfd_loop_filter.sv
// rtl/pfd_loop_filter.sv - PI loop filter turning PFD fast/slow pulse widths into DCO maxVal/duty words
// Ports: clk - system clock; reset - async active-low reset; fast/slow - raw PFD levels;
//        hold - freeze integrator/outputs; maxVal - DCO period word; duty - maxVal>>1;
//        upd - one-cycle strobe on output change; locked - lock indicator.
// Build option: define LOCK_DETECT_EN to build the lock counter; otherwise locked is tied 0.
module pfd_loop_filter
  import pfd_loop_filter_pkg::*;
#(
  parameter int W        = PLF_W_DEF,
  parameter int EW       = PLF_EW_DEF,
  parameter int KP_SHIFT = PLF_KP_SHIFT_DEF,
  parameter int KI_SHIFT = PLF_KI_SHIFT_DEF,
  parameter int INIT_VAL = PLF_INIT_VAL_DEF,
  parameter int MIN_VAL  = PLF_MIN_VAL_DEF,
  parameter int MAX_VAL  = PLF_MAX_VAL_DEF,
  parameter int LOCK_TOL = PLF_LOCK_TOL_DEF,
  parameter int LOCK_CNT = PLF_LOCK_CNT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fast,
  input  logic         slow,
  input  logic         hold,
  output logic [W-1:0] maxVal,
  output logic [W-1:0] duty,
  output logic         upd,
  output logic         locked
);

  // Two guard bits above W+KI_SHIFT keep integ+err and the P+I sum from wrapping before clamping.
  localparam int IW = W + KI_SHIFT + 2;

  localparam logic signed [EW-1:0] ERR_SAT_POS = EW'((1 << (EW - 1)) - 1);
  localparam logic signed [EW-1:0] ERR_SAT_NEG = -ERR_SAT_POS;
  localparam logic signed [EW-1:0] ERR_ONE     = EW'(1);
  localparam logic signed [IW-1:0] INTEG_LO    = IW'(MIN_VAL << KI_SHIFT);
  localparam logic signed [IW-1:0] INTEG_HI    = IW'(MAX_VAL << KI_SHIFT);
  localparam logic signed [IW-1:0] INTEG_INIT  = IW'(INIT_VAL << KI_SHIFT);
  localparam logic signed [IW-1:0] CTRL_LO     = IW'(MIN_VAL);
  localparam logic signed [IW-1:0] CTRL_HI     = IW'(MAX_VAL);
  localparam logic [W-1:0]         VAL_MIN     = W'(MIN_VAL);
  localparam logic [W-1:0]         VAL_MAX     = W'(MAX_VAL);
  localparam logic [W-1:0]         VAL_INIT    = W'(INIT_VAL);

  logic f_s, s_s;

  pfd_sync2 u_sync_fast (
    .clk   (clk),
    .reset (reset),
    .d     (fast),
    .q     (f_s)
  );

  pfd_sync2 u_sync_slow (
    .clk   (clk),
    .reset (reset),
    .d     (slow),
    .q     (s_s)
  );

  plf_state_e           state_q, state_d;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic [W-1:0]         max_val_q, max_val_d;
  logic                 upd_q, upd_d;

  logic signed [IW-1:0] err_ext;
  logic signed [IW-1:0] integ_sum;
  logic signed [IW-1:0] integ_clamped;
  logic signed [IW-1:0] ctrl_raw;
  logic [W-1:0]         ctrl_clamped;

  // Candidate update, valid whenever the FSM sits in UPDATE.
  always_comb begin
    err_ext   = {{(IW - EW){err_q[EW-1]}}, err_q};
    integ_sum = integ_q + err_ext;
    if (integ_sum < INTEG_LO) begin
      integ_clamped = INTEG_LO;
    end else if (integ_sum > INTEG_HI) begin
      integ_clamped = INTEG_HI;
    end else begin
      integ_clamped = integ_sum;
    end
    // Integral term uses the freshly clamped integrator; proportional term uses this pulse only.
    ctrl_raw = (integ_clamped >>> KI_SHIFT) + (err_ext >>> KP_SHIFT);
    if (ctrl_raw < CTRL_LO) begin
      ctrl_clamped = VAL_MIN;
    end else if (ctrl_raw > CTRL_HI) begin
      ctrl_clamped = VAL_MAX;
    end else begin
      ctrl_clamped = ctrl_raw[W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    integ_d   = integ_q;
    max_val_d = max_val_q;
    upd_d     = 1'b0;
    case (state_q)
      PLF_IDLE: begin
        if (f_s ^ s_s) begin
          state_d = PLF_MEASURE;
          err_d   = s_s ? ERR_ONE : -ERR_ONE;
        end
      end
      PLF_MEASURE: begin
        if (s_s && !f_s) begin
          if (err_q != ERR_SAT_POS) err_d = err_q + ERR_ONE;
        end else if (f_s && !s_s) begin
          if (err_q != ERR_SAT_NEG) err_d = err_q - ERR_ONE;
        end else if (!f_s && !s_s) begin
          state_d = PLF_UPDATE;
        end
        // f_s && s_s is the PFD reset overlap: err holds, stay measuring.
      end
      PLF_UPDATE: begin
        if (!hold) begin
          integ_d   = integ_clamped;
          max_val_d = ctrl_clamped;
          upd_d     = 1'b1;
        end
        state_d = PLF_IDLE;
        err_d   = '0;
      end
      default: begin
        state_d = PLF_IDLE;
        err_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PLF_IDLE;
      err_q     <= '0;
      integ_q   <= INTEG_INIT;
      max_val_q <= VAL_INIT;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      integ_q   <= integ_d;
      max_val_q <= max_val_d;
      upd_q     <= upd_d;
    end
  end

  assign maxVal = max_val_q;
  assign duty   = max_val_q >> 1;
  assign upd    = upd_q;

`ifdef LOCK_DETECT_EN
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0] LOCK_FULL  = LCW'(LOCK_CNT);
  localparam logic [EW-1:0]  LOCK_TOL_V = EW'(LOCK_TOL);

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic [EW-1:0]  err_mag;

  // err never reaches the most negative code, so the negation cannot overflow.
  always_comb begin
    err_mag    = err_q[EW-1] ? EW'(-err_q) : EW'(err_q);
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (state_q == PLF_UPDATE && !hold) begin
      if (err_mag <= LOCK_TOL_V) begin
        if (lock_cnt_q != LOCK_FULL) lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        lock_cnt_d = '0;
      end
      locked_d = (lock_cnt_d == LOCK_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{LOCK_TOL, LOCK_CNT};
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_loop_filter.sv
// tb/tb_pfd_loop_filter.sv - directed self-checking bench for pfd_loop_filter against a behavioural model
`timescale 1ns/1ps
module tb_pfd_loop_filter;

  localparam int INIT_VAL = 128;
  localparam int MIN_VAL  = 2;
  localparam int MAX_VAL  = 255;
  localparam int KI_DIV   = 8;
  localparam int KP_DIV   = 2;
  localparam int ERR_SAT  = 127;
  localparam int LOCK_TOL = 1;
  localparam int LOCK_CNT = 4;
`ifdef LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fast = 1'b0;
  logic       slow = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] maxVal, duty;
  logic       upd, locked;

  pfd_loop_filter dut (
    .clk    (clk),
    .reset  (reset),
    .fast   (fast),
    .slow   (slow),
    .hold   (hold),
    .maxVal (maxVal),
    .duty   (duty),
    .upd    (upd),
    .locked (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int val;
    bit lk;
  } exp_t;
  exp_t exp_q[$];

  int m_integ = INIT_VAL * KI_DIV;
  int m_lock  = 0;
  int exp_max = INIT_VAL;
  bit exp_lock = 1'b0;

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_integ = INIT_VAL * KI_DIV;
    m_lock  = 0;
    exp_q.delete();
  endtask

  // Every negedge: upd must appear exactly on the predicted cycle, and outputs must track the model.
  initial begin : cmp
    bit want_upd;
    forever begin
      @(negedge clk);
      want_upd = 1'b0;
      if (!reset) begin
        exp_max  = INIT_VAL;
        exp_lock = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        want_upd = 1'b1;
        exp_max  = exp_q[0].val;
        exp_lock = exp_q[0].lk;
        void'(exp_q.pop_front());
      end
      chk("upd", int'(upd), int'(want_upd));
      chk("maxVal", int'(maxVal), exp_max);
      chk("duty", int'(duty), exp_max / 2);
      chk("locked", int'(locked), int'(exp_lock));
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    slow  = 1'b0;
    fast  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // Raw pulse of n clk; the model predicts err, integrator, output word and strobe cycle.
  task automatic pulse(input bit is_slow, input int n);
    int err, ctrl, mag;
    @(posedge clk);
    #1;
    if (is_slow) slow = 1'b1;
    else         fast = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    slow = 1'b0;
    fast = 1'b0;
    if (!hold) begin
      err     = clampi(is_slow ? n : -n, -ERR_SAT, ERR_SAT);
      m_integ = clampi(m_integ + err, MIN_VAL * KI_DIV, MAX_VAL * KI_DIV);
      ctrl    = clampi(fdiv(m_integ, KI_DIV) + fdiv(err, KP_DIV), MIN_VAL, MAX_VAL);
      mag     = (err < 0) ? -err : err;
      if (mag <= LOCK_TOL) m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : LOCK_CNT;
      else                 m_lock = 0;
      exp_q.push_back('{cyc + 4, ctrl, LOCK_EN && (m_lock == LOCK_CNT)});
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_maxVal", int'(maxVal), 128);
    chk("rst_duty", int'(duty), 64);
    chk("rst_upd", int'(upd), 0);
    chk("rst_locked", int'(locked), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    pulse(1'b1, 8);
    @(negedge clk);
    chk("slow8_integ_model", m_integ, 1032);
    chk("slow8_maxVal", int'(maxVal), 133);
    chk("slow8_duty", int'(duty), 66);

    do_reset();
    pulse(1'b0, 8);
    @(negedge clk);
    chk("fast8_integ_model", m_integ, 1016);
    chk("fast8_maxVal", int'(maxVal), 123);
    chk("fast8_duty", int'(duty), 61);

    for (int i = 0; i < 20; i++) pulse(1'b0, 100);
    @(negedge clk);
    chk("fastclamp_integ_model", m_integ, 16);
    chk("fastclamp_maxVal", int'(maxVal), 2);
    chk("fastclamp_duty", int'(duty), 1);

    do_reset();
    pulse(1'b1, 200);
    @(negedge clk);
    chk("slowsat_maxVal", int'(maxVal), 206);
    chk("slowsat_duty", int'(duty), 103);

    do_reset();
    hold = 1'b1;
    pulse(1'b1, 8);
    @(negedge clk);
    chk("hold_maxVal", int'(maxVal), 128);
    hold = 1'b0;
    pulse(1'b1, 8);
    @(negedge clk);
    chk("after_hold_maxVal", int'(maxVal), 133);

    // Reset while a pulse is being measured: partial pulse must be dropped.
    @(posedge clk);
    #1;
    slow = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    slow  = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_maxVal", int'(maxVal), 128);
    chk("midrst_duty", int'(duty), 64);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst_after_maxVal", int'(maxVal), 128);

    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1);
    @(negedge clk);
    chk("lock4_maxVal", int'(maxVal), 128);
    chk("lock4_locked", int'(locked), LOCK_EN ? 1 : 0);
    pulse(1'b1, 5);
    @(negedge clk);
    chk("unlock_maxVal", int'(maxVal), 131);
    chk("unlock_locked", int'(locked), 0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
